// File: rtl/mem_bist_pkg.sv
// Shared types and default widths for the BIST fail logger.
package mem_bist_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int AD_WIDTH_DEF   = 4;
  localparam int LOG_DEPTH_DEF  = 4;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_fail_log_if.sv
// Compare/report bus of the fail logger; log_ovf exists only with FAIL_LOG_OVERFLOW_EN.
interface mem_fail_log_if import mem_bist_pkg::*; #(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int ad_width   = AD_WIDTH_DEF,
  parameter int cnt_width  = CNT_WIDTH_DEF
);
  logic                  start;
  logic                  cmp_valid;
  logic [ad_width-1:0]   cmp_addr;
  logic [data_width-1:0] cmp_exp;
  logic [data_width-1:0] cmp_act;
  logic                  bist_done;
  logic                  rd_en;
  logic                  fail;
  logic                  done;
  logic [cnt_width-1:0]  fail_cnt;
  logic                  rd_valid;
  logic [ad_width-1:0]   rd_addr;
  logic [data_width-1:0] rd_syn;
  logic                  log_empty;
`ifdef FAIL_LOG_OVERFLOW_EN
  logic                  log_ovf;
`endif

  modport master (
    output start, cmp_valid, cmp_addr, cmp_exp, cmp_act, bist_done, rd_en,
`ifdef FAIL_LOG_OVERFLOW_EN
    input  log_ovf,
`endif
    input  fail, done, fail_cnt, rd_valid, rd_addr, rd_syn, log_empty
  );

  modport slave (
    input  start, cmp_valid, cmp_addr, cmp_exp, cmp_act, bist_done, rd_en,
`ifdef FAIL_LOG_OVERFLOW_EN
    output log_ovf,
`endif
    output fail, done, fail_cnt, rd_valid, rd_addr, rd_syn, log_empty
  );

endinterface

// File: rtl/fail_log_fifo.sv
// Small FIFO holding captured fail entries; synchronous write, registered read, clear input.
module fail_log_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(depth);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [width-1:0] mem_q [depth];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [width-1:0] rd_data_q, rd_data_d;
  logic             do_wr, do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    do_wr     = wr_en && !full && !clr;
    do_rd     = rd_en && !empty && !clr;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = mem_q[rd_ptr_q[PW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_fail_log.sv
// BIST fail logger: counts read-phase mismatches and buffers the oldest ones for readout.
// Optional sticky overflow flag log_ovf is built when FAIL_LOG_OVERFLOW_EN is defined.
module mem_fail_log import mem_bist_pkg::*; #(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int ad_width   = AD_WIDTH_DEF,
  parameter int log_depth  = LOG_DEPTH_DEF,
  parameter int cnt_width  = CNT_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_fail_log_if.slave bus
);

  localparam int ENTRY_W = ad_width + data_width;
  localparam logic [cnt_width-1:0] CNT_ONE = 1;

  state_e               state_q, state_d;
  logic                 fail_q, fail_d;
  logic [cnt_width-1:0] fail_cnt_q, fail_cnt_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 done, clr, mismatch, pop;
  logic                 log_full, log_empty;
  logic [ENTRY_W-1:0]   wr_entry, rd_entry;
`ifdef FAIL_LOG_OVERFLOW_EN
  logic                 ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start)     state_d = ST_CAPTURE;
      ST_CAPTURE: if (bus.bist_done) state_d = ST_REPORT;
      ST_REPORT:  if (bus.start)     state_d = ST_CAPTURE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // start is a restart everywhere except CAPTURE; in REPORT it also wins over rd_en.
  always_comb begin
    done     = (state_q == ST_REPORT);
    clr      = bus.start && (state_q != ST_CAPTURE);
    mismatch = (state_q == ST_CAPTURE) && bus.cmp_valid && (bus.cmp_exp != bus.cmp_act);
    pop      = (state_q == ST_REPORT) && bus.rd_en && !bus.start && !log_empty;
  end

  always_comb begin
    fail_d     = clr ? 1'b0 : (fail_q | mismatch);
    fail_cnt_d = fail_cnt_q;
    if (clr)
      fail_cnt_d = '0;
    else if (mismatch && (fail_cnt_q != '1))
      fail_cnt_d = fail_cnt_q + CNT_ONE;
    rd_valid_d = pop;
    wr_entry   = {bus.cmp_addr, bus.cmp_exp ^ bus.cmp_act};
`ifdef FAIL_LOG_OVERFLOW_EN
    ovf_d      = clr ? 1'b0 : (ovf_q | (mismatch && log_full));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_q     <= 1'b0;
      fail_cnt_q <= '0;
      rd_valid_q <= 1'b0;
`ifdef FAIL_LOG_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
      rd_valid_q <= rd_valid_d;
`ifdef FAIL_LOG_OVERFLOW_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  // Once full, new mismatches are dropped so the earliest failures survive.
  fail_log_fifo #(
    .width (ENTRY_W),
    .depth (log_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (mismatch && !log_full),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (log_full),
    .empty   (log_empty)
  );

  assign bus.fail      = fail_q;
  assign bus.done      = done;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_addr   = rd_entry[ENTRY_W-1:data_width];
  assign bus.rd_syn    = rd_entry[data_width-1:0];
  assign bus.log_empty = log_empty;
`ifdef FAIL_LOG_OVERFLOW_EN
  assign bus.log_ovf   = ovf_q;
`endif

endmodule

// File: doc/mem_fail_log.md
MEM_FAIL_LOG -- requirements
Module: mem_fail_log

Interface
REQ-001 SHALL have parameter data_width, default 4, memory word width.
REQ-002 SHALL have parameter ad_width, default 4, memory address width.
REQ-003 SHALL have parameter log_depth, default 4, number of fail entries held (power of 2, >=2).
REQ-004 SHALL have parameter cnt_width, default 8, fail counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse, arms capture and clears log/counter.
REQ-008 cmp_valid  in  1  compare result from BIST read phase valid this cycle.
REQ-009 cmp_addr  in  ad_width  address of compared word.
REQ-010 cmp_exp  in  data_width  expected data.
REQ-011 cmp_act  in  data_width  data read from memory.
REQ-012 bist_done  in  1  upstream BIST sequence finished.
REQ-013 rd_en  in  1  pop one log entry (honoured in REPORT only).
REQ-014 fail  out  1  sticky, at least one mismatch since last start.
REQ-015 done  out  1  high in REPORT.
REQ-016 fail_cnt  out  cnt_width  mismatch count, saturating.
REQ-017 rd_valid, rd_addr (ad_width), rd_syn (data_width)  out  popped entry; rd_syn = exp XOR act.
REQ-018 log_empty  out  1  no entries held.

Function
REQ-019 SHALL implement states IDLE, CAPTURE, REPORT.
REQ-020 IDLE: start -> CAPTURE; in the same edge log, fail, fail_cnt SHALL clear.
REQ-021 CAPTURE: cmp_valid with cmp_exp != cmp_act SHALL set fail, increment fail_cnt (hold at all-ones), write {cmp_addr, exp^act} to log if not full.
REQ-022 Mismatch with log full SHALL be counted but not stored; oldest entries retained.
REQ-023 CAPTURE: bist_done -> REPORT; a mismatch in the same cycle SHALL still be captured.
REQ-024 start during CAPTURE SHALL be ignored.
REQ-025 REPORT: rd_en with log non-empty SHALL pop in FIFO order; rd_valid high exactly one cycle later with entry data; rd_en on empty SHALL give rd_valid=0, no state change.
REQ-026 REPORT: start -> CAPTURE with clear (REQ-020); a coincident rd_en SHALL be ignored.
REQ-027 rd_addr/rd_syn SHALL hold last popped value when rd_valid=0.
REQ-028 cmp_valid outside CAPTURE SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE, fail=0, done=0, fail_cnt=0, rd_valid=0, rd_addr=0, rd_syn=0, log_empty=1, pointers 0; rst SHALL override all inputs, including mid-CAPTURE and mid-REPORT.

Configuration
REQ-030 With FAIL_LOG_OVERFLOW_EN defined, port log_ovf (out, 1) SHALL exist, set sticky when a mismatch is dropped per REQ-022, cleared by rst/start.
REQ-031 Without FAIL_LOG_OVERFLOW_EN, log_ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package mem_bist_pkg SHALL hold the state enum and default width constants (data 4, addr 4, depth 4, cnt 8).
REQ-033 Storage SHALL be sub-module fail_log_fifo (sync write/read, full/empty, clear input).

Verification
REQ-034 Reset then start, 16 matching compares, bist_done -> fail=0, fail_cnt=0, done=1, log_empty=1.
REQ-035 Mismatch addr 3 exp 4'hA act 4'h8 -> fail=1, fail_cnt=1; rd_en in REPORT -> next cycle rd_valid=1, rd_addr=3, rd_syn=4'h2.
REQ-036 6 mismatches, addrs 1..6 -> fail_cnt=6; pops return addrs 1,2,3,4 then log_empty=1; log_ovf=1 when macro defined.
REQ-037 cnt_width=2, 5 mismatches -> fail_cnt saturates at 3.
REQ-038 Mismatch coincident with bist_done -> logged, fail_cnt incremented; rd_en on empty log -> rd_valid=0.
REQ-039 rst asserted mid-CAPTURE after 2 mismatches -> all outputs at reset values next cycle; start in REPORT clears fail_cnt to 0.
